// File: rtl/serdes_pkg.sv
// serdes_pkg: shared FSM state type and counter-width helper for the SERDES parallel path.
package serdes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Word-select counter width; a single-word message still needs one bit.
    function automatic int SER_CW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serializer_control.sv
// serializer_control: two-state FSM and word counter sequencing one message out word by word.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   recv_val : upstream message valid
//   send_rdy : downstream accepts current word
//   recv_rdy : block can accept a message (forced low while reset is held)
//   send_val : current word valid
//   load_en  : capture the incoming message this cycle
//   sel      : index of the word being presented
module serializer_control
    import serdes_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int CW        = SER_CW(N_SAMPLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          recv_val,
    input  logic          send_rdy,
    output logic          recv_rdy,
    output logic          send_val,
    output logic          load_en,
    output logic [CW-1:0] sel
);

    ser_state_t    state, state_n;
    logic [CW-1:0] count, count_n;
    logic          xfer, last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    always_comb begin
        recv_rdy = reset && (state == IDLE);
        send_val = (state == SEND);
        load_en  = recv_val && recv_rdy;
        xfer     = send_val && send_rdy;
        last     = (count == CW'(N_SAMPLES - 1));
        state_n  = load_en ? SEND : (xfer && last) ? IDLE : state;
        count_n  = load_en ? '0 : xfer ? (last ? '0 : count + CW'(1)) : count;
        sel      = count;
    end

endmodule

// File: rtl/serializer.sv
// serializer: parallel-to-serial converter, one N_SAMPLES-word message out lowest word first.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   recv_msg : parallel message, word i at [i*BIT_WIDTH +: BIT_WIDTH]
//   recv_val : recv_msg valid
//   recv_rdy : block can accept a message
//   send_msg : current serial word (zero when not valid)
//   send_val : send_msg valid
//   send_rdy : downstream accepts send_msg
module serializer
    import serdes_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int N_SAMPLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [BIT_WIDTH-1:0]           send_msg,
    output logic                           send_val,
    input  logic                           send_rdy
);

    localparam int CW = SER_CW(N_SAMPLES);

    // Packed word view so the select indexes whole words directly.
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] msg_reg;
    logic                                load_en;
    logic [CW-1:0]                       sel;

    serializer_control #(
        .N_SAMPLES(N_SAMPLES),
        .CW       (CW)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .recv_val(recv_val),
        .send_rdy(send_rdy),
        .recv_rdy(recv_rdy),
        .send_val(send_val),
        .load_en (load_en),
        .sel     (sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            msg_reg <= '0;
        else if (load_en)
            msg_reg <= recv_msg;
    end

    always_comb send_msg = send_val ? msg_reg[sel] : '0;

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial converter for the SERDES parallel path: accepts one wide message of `N_SAMPLES` words over a val/rdy handshake and emits it word-by-word, lowest word first, over a second val/rdy handshake. It is the transmit-side counterpart of the deserializer control/datapath, and its output stream reassembles bit-exactly at the deserializer. It holds one message of buffering, with a counter-driven word select and a two-state FSM.

## Interface
- `BIT_WIDTH`, default 8: width of one serial word.
- `N_SAMPLES`, default 4: words per parallel message; legal range ≥1.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low (`reset == 0` resets).
- `recv_msg`  in  `N_SAMPLES*BIT_WIDTH`: parallel message; word i = bits `[i*BIT_WIDTH +: BIT_WIDTH]`.
- `recv_val`  in  1: `recv_msg` valid.
- `recv_rdy`  out  1: block can accept a message.
- `send_msg`  out  `BIT_WIDTH`: current serial word.
- `send_val`  out  1: `send_msg` valid.
- `send_rdy`  in  1: downstream accepts `send_msg`.

## Operation
- Storage: `msg_reg` (`N_SAMPLES*BIT_WIDTH`), counter `count` of width `CW = max(1, $clog2(N_SAMPLES))`, state register.
- States: IDLE, SEND.
- IDLE: `recv_rdy = 1`, `send_val = 0`, `send_msg = 0`. On `recv_val && recv_rdy`: `msg_reg <= recv_msg`, `count <= 0`, next SEND. Otherwise stay in IDLE; `msg_reg` holds.
- SEND: `recv_rdy = 0`, `send_val = 1`, `send_msg = msg_reg[count*BIT_WIDTH +: BIT_WIDTH]`. On `send_val && send_rdy`:
  - if `count == N_SAMPLES-1`: `count <= 0`, next IDLE.
  - else `count <= count + 1`, stay in SEND.
- `send_rdy` low in SEND: all state holds. `send_msg` must remain stable while `send_val` is high and not accepted.
- `recv_val` in SEND is ignored because `recv_rdy = 0`. `recv_msg` may change freely after the accept cycle.
- Outputs are decoded from registered state only. There is no combinational path from `recv_val` or `send_rdy` to any output.
- `N_SAMPLES == 1`: every SEND transfer is the last one, so the block goes IDLE→SEND→IDLE.
- `count` never exceeds `N_SAMPLES-1`. Wrap to 0 happens only on the last transfer.

## Timing
- Reset (`reset == 0`, asynchronous): state = IDLE, `count = 0`, `msg_reg = 0`. While reset is held: `recv_rdy = 0` (gated by `reset`), `send_val = 0`, `send_msg = 0`. The first cycle after release has `recv_rdy = 1`.
- Reset during SEND aborts the message immediately. No further words are emitted, and the partially sent message is discarded.
- Latency: message accepted at edge k → word 0 valid during cycle k+1.
- With `send_rdy` held high: words 0..N-1 appear in cycles k+1..k+N, and `recv_rdy` is high again in cycle k+N+1.
- Throughput: one message per `N_SAMPLES+1` cycles. There is a deliberate one-cycle IDLE bubble and no overlap of accept with the last send.

## Structure
- Package `serdes_pkg`: state enum (IDLE=1'b0, SEND=1'b1), plus a `SER_CW(N)` width helper shared with the deserializer.
- Sub-module `serializer_control`: FSM plus counter. Inputs `recv_val`, `send_rdy`; outputs `recv_rdy`, `send_val`, `load_en`, `sel[CW-1:0]`.
- Top `serializer`: `msg_reg` load and word mux (`sel`), instantiating `serializer_control`.

## Test plan
- Reset: hold `reset = 0` for 3 cycles with `recv_val = 1` → `recv_rdy = 0`, `send_val = 0`, `send_msg = 0`. After release → `recv_rdy = 1`, no message captured.
- Basic (W=8, N=4): `recv_msg = 32'hDDCCBBAA`, `send_rdy = 1` → `send_msg` = AA, BB, CC, DD in 4 consecutive cycles, then `recv_rdy = 1` on the next cycle.
- Backpressure: same message, `send_rdy` low for 3 cycles while BB is presented → BB stays stable with `send_val = 1`. Sequence completes AA, BB, CC, DD with no loss or duplication.
- Busy drop: in SEND, drive `recv_val = 1` with 32'h44332211 → ignored. After DD, a fresh accept of 32'h44332211 yields 11, 22, 33, 44.
- Mid-message reset: assert reset after CC has been accepted → `send_val = 0` asynchronously. After release, the block is IDLE and DD is never sent.
- N_SAMPLES=1, W=16: back-to-back messages 16'hBEEF, 16'hCAFE with `send_rdy = 1` → BEEF, bubble, CAFE; `count` stays 0.
